// File: rtl/dma_irq_coalescer_pkg.sv
// Shared definitions for the DMA interrupt coalescer: register map,
// register-port types and the packed CFG layout.
package dma_irq_coalescer_pkg;

  localparam logic [1:0] REG_CFG     = 2'd0;
  localparam logic [1:0] REG_TIMEOUT = 2'd1;
  localparam logic [1:0] REG_COUNT   = 2'd2;
  localparam logic [1:0] REG_CLEAR   = 2'd3;

  localparam int unsigned SRC_STRIDE = 32'h20;
  localparam int unsigned SRC_SHIFT  = $clog2(SRC_STRIDE);
  localparam int unsigned ADDR_WIDTH = 32;

  typedef struct packed {
    logic                  valid;
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [63:0]           wdata;
    logic [7:0]            wstrb;
  } coal_reg_req_t;

  typedef struct packed {
    logic        ready;
    logic [63:0] rdata;
    logic        error;
  } coal_reg_rsp_t;

  // CFG register layout; threshold is wider than any legal counter and is
  // truncated to the counter width where it is used.
  typedef struct packed {
    logic [47:0] threshold;
    logic [14:0] reserved;
    logic        enable;
  } cfg_t;

  function automatic logic [63:0] apply_wstrb(input logic [63:0] old_val,
                                              input logic [63:0] wdata,
                                              input logic [7:0]  wstrb);
    logic [63:0] res;
    res = old_val;
    for (int b = 0; b < 8; b++) begin
      if (wstrb[b]) res[b*8 +: 8] = wdata[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dma_irq_coalescer_chan.sv
// One coalescing channel: saturating event counter with sticky overflow,
// timer since the first uncleared event, and the registered interrupt.
// enable/threshold/timeout are the values the config registers will hold
// after this edge, so reconfiguration is seen by irq_o one cycle later.
module dma_irq_coalescer_chan #(
  parameter int unsigned CntWidth = 16,
  parameter int unsigned TmoWidth = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                event_i,
  input  logic                clear_i,
  input  logic                enable_i,
  input  logic [CntWidth-1:0] threshold_i,
  input  logic [TmoWidth-1:0] timeout_i,
  output logic [CntWidth-1:0] count_o,
  output logic                ovf_o,
  output logic                irq_o
);

  logic [CntWidth-1:0] count_q, count_d, count_base;
  logic                ovf_q, ovf_d;
  logic [TmoWidth-1:0] timer_q, timer_d;
  logic                irq_q, irq_d;
  logic                thr_hit, tmo_hit;

  // Next-state: clear first, then the event; interrupt from next-state values.
  always_comb begin
    count_base = clear_i ? '0 : count_q;
    ovf_d      = clear_i ? 1'b0 : ovf_q;
    count_d    = count_base;
    if (event_i) begin
      if (&count_base) ovf_d = 1'b1;
      else             count_d = count_base + 1'b1;
    end

    // A first event (from empty or right after a clear) starts the timer at 0.
    if (count_d == '0 || clear_i || count_q == '0) timer_d = '0;
    else if (timer_q >= timeout_i)                   timer_d = timeout_i;
    else                                             timer_d = timer_q + 1'b1;

    thr_hit = (threshold_i != '0) && (count_d >= threshold_i);
    tmo_hit = (timeout_i != '0) && (count_d != '0) && (timer_d == timeout_i);
    irq_d   = enable_i && (thr_hit || tmo_hit);
  end

  // Channel state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      timer_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      timer_q <= timer_d;
      irq_q   <= irq_d;
    end
  end

  assign count_o = count_q;
  assign ovf_o   = ovf_q;
  assign irq_o   = irq_q;

endmodule

// File: rtl/dma_irq_coalescer.sv
// Interrupt coalescer top: register decode/storage, read mux, error
// responses and one coalescing channel per DMA interrupt source.
module dma_irq_coalescer
  import dma_irq_coalescer_pkg::*;
#(
  parameter int unsigned NumSrc   = 2,
  parameter int unsigned CntWidth = 16,
  parameter int unsigned TmoWidth = 32,
  parameter type reg_req_t = coal_reg_req_t,
  parameter type reg_rsp_t = coal_reg_rsp_t
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NumSrc-1:0] irq_i,
  input  reg_req_t          reg_req_i,
  output reg_rsp_t          reg_rsp_o,
  output logic [NumSrc-1:0] irq_o
);

  // Implemented bits: enable plus the threshold field; low TmoWidth bits.
  localparam logic [63:0] CFG_MASK = (((64'd1 << CntWidth) - 64'd1) << 16) | 64'd1;
  localparam logic [63:0] TMO_MASK = (64'd1 << TmoWidth) - 64'd1;

  logic [NumSrc-1:0][63:0]         cfg_q, cfg_d, tmo_q, tmo_d;
  logic [NumSrc-1:0]               clear;
  logic [NumSrc-1:0][CntWidth-1:0] count;
  logic [NumSrc-1:0]               ovf;
  logic [31:0]                     src_sel;
  logic [1:0]                      reg_sel;
  logic                            in_range, acc_err, wr_ok;
  logic [63:0]                     rd_data;

  assign src_sel  = 32'(reg_req_i.addr >> SRC_SHIFT);
  assign reg_sel  = reg_req_i.addr[4:3];
  assign in_range = src_sel < NumSrc;
  assign acc_err  = reg_req_i.valid &&
                    (!in_range || (reg_req_i.write && reg_sel == REG_COUNT));
  assign wr_ok    = reg_req_i.valid && reg_req_i.write && !acc_err;

  // Write decode: next config values and per-source clear strobes.
  always_comb begin
    cfg_d = cfg_q;
    tmo_d = tmo_q;
    clear = '0;
    for (int unsigned i = 0; i < NumSrc; i++) begin
      if (wr_ok && src_sel == i) begin
        case (reg_sel)
          REG_CFG:     cfg_d[i] = apply_wstrb(cfg_q[i], reg_req_i.wdata, reg_req_i.wstrb) & CFG_MASK;
          REG_TIMEOUT: tmo_d[i] = apply_wstrb(tmo_q[i], reg_req_i.wdata, reg_req_i.wstrb) & TMO_MASK;
          REG_CLEAR:   clear[i] = |reg_req_i.wstrb;
          default:     ;
        endcase
      end
    end
  end

  // Read mux and combinational response; errors return zero data.
  always_comb begin
    rd_data = '0;
    for (int unsigned i = 0; i < NumSrc; i++) begin
      if (src_sel == i) begin
        case (reg_sel)
          REG_CFG:     rd_data = cfg_q[i];
          REG_TIMEOUT: rd_data = tmo_q[i];
          REG_COUNT: begin
            rd_data[CntWidth-1:0] = count[i];
            rd_data[63]           = ovf[i];
          end
          default:     rd_data = '0;
        endcase
      end
    end
    reg_rsp_o       = '0;
    reg_rsp_o.ready = 1'b1;
    reg_rsp_o.error = acc_err;
    if (reg_req_i.valid && !acc_err) reg_rsp_o.rdata = rd_data;
  end

  // Configuration register storage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cfg_q <= '0;
      tmo_q <= '0;
    end else begin
      cfg_q <= cfg_d;
      tmo_q <= tmo_d;
    end
  end

  for (genvar g = 0; g < NumSrc; g++) begin : g_src
    cfg_t cfg_nxt;
    logic unused_cfg;
    assign cfg_nxt    = cfg_t'(cfg_d[g]);
    assign unused_cfg = ^{cfg_nxt.reserved, cfg_nxt.threshold, tmo_d[g]};

    dma_irq_coalescer_chan #(
      .CntWidth(CntWidth),
      .TmoWidth(TmoWidth)
    ) u_chan (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .event_i    (irq_i[g]),
      .clear_i    (clear[g]),
      .enable_i   (cfg_nxt.enable),
      .threshold_i(cfg_nxt.threshold[CntWidth-1:0]),
      .timeout_i  (tmo_d[g][TmoWidth-1:0]),
      .count_o    (count[g]),
      .ovf_o      (ovf[g]),
      .irq_o      (irq_o[g])
    );
  end

endmodule
